// File: rtl/corr_argmax_pkg.sv
// Shared definitions for the correlation argmax block: default data width,
// FSM encoding and the accumulator / index width derivations.
package corr_argmax_pkg;

   localparam int VMU_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Enough headroom for BEATS worst-case partial sums.
   function automatic int acc_width(input int data_width, input int beats);
      return data_width + $clog2(beats);
   endfunction

   function automatic int idx_width(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

endpackage

// File: rtl/corr_argmax_if.sv
// Partial-sum stream in, per-column correlation and running argmax out.
interface corr_argmax_if
   import corr_argmax_pkg::*;
#(
   parameter int DATA_WIDTH = VMU_DATA_WIDTH,
   parameter int BEATS      = 4,
   parameter int COLS       = 256
);
   localparam int ACC_W = acc_width(DATA_WIDTH, BEATS);
   localparam int IDX_W = idx_width(COLS);

   logic                         start;
   logic                         in_valid;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         in_ready;
   logic                         corr_valid;
   logic signed [ACC_W-1:0]      corr_out;
   logic        [IDX_W-1:0]      corr_idx;
   logic        [ACC_W-1:0]      max_val;
   logic        [IDX_W-1:0]      max_idx;
   logic                         done;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, corr_valid, corr_out, corr_idx, max_val, max_idx, done
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, corr_valid, corr_out, corr_idx, max_val, max_idx, done
   );

endinterface

// File: rtl/corr_argmax_abs_max_cmp.sv
// Saturating |x| of a signed inner product and strict compare against the
// current maximum magnitude.
module abs_max_cmp #(
   parameter int W = 18
) (
   input  logic signed [W-1:0] value,
   input  logic        [W-1:0] cur_max,
   output logic        [W-1:0] abs_val,
   output logic                greater
);

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

   // NOTE: every output is assigned on every path, so no latch is inferred.
   always_comb begin
      if ($unsigned(value) == MOST_NEG) begin
         abs_val = MOST_POS;
      end else if (value[W-1]) begin
         abs_val = $unsigned(-value);
      end else begin
         abs_val = $unsigned(value);
      end
      greater = (abs_val > cur_max);
   end

endmodule

// File: rtl/corr_argmax.sv
// Accumulates BEATS partial sums per dictionary column and tracks the column
// with the largest |inner product| over a COLS-column search.
module corr_argmax
   import corr_argmax_pkg::*;
#(
   parameter int DATA_WIDTH = VMU_DATA_WIDTH,
   parameter int BEATS      = 4,
   parameter int COLS       = 256
) (
   input logic         clk,
   input logic         rst,
   corr_argmax_if.slave bus
);

   localparam int ACC_W  = acc_width(DATA_WIDTH, BEATS);
   localparam int IDX_W  = idx_width(COLS);
   localparam int BEAT_W = $clog2(BEATS);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(COLS - 1);

   state_e                  state;
   logic signed [ACC_W-1:0] acc;
   logic [BEAT_W-1:0]       beat;
   logic [IDX_W-1:0]        col;

   logic signed [ACC_W-1:0] data_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    accept;
   logic [ACC_W-1:0]        abs_val;
   logic                    greater;

   assign data_ext = {{(ACC_W-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
   assign acc_sum  = acc + data_ext;
   assign accept   = bus.in_valid && bus.in_ready;

   abs_max_cmp #(.W(ACC_W)) u_cmp (
      .value   (bus.corr_out),
      .cur_max (bus.max_val),
      .abs_val (abs_val),
      .greater (greater)
   );

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         acc            <= '0;
         beat           <= '0;
         col            <= '0;
         bus.in_ready   <= 1'b0;
         bus.corr_valid <= 1'b0;
         bus.corr_out   <= '0;
         bus.corr_idx   <= '0;
         bus.max_val    <= '0;
         bus.max_idx    <= '0;
         bus.done       <= 1'b0;
      end else if (bus.start) begin
         // A start in any state opens a fresh search and drops in-flight work.
         state          <= ST_ACCUM;
         acc            <= '0;
         beat           <= '0;
         col            <= '0;
         bus.in_ready   <= 1'b1;
         bus.corr_valid <= 1'b0;
         bus.max_val    <= '0;
         bus.max_idx    <= '0;
         bus.done       <= 1'b0;
      end else begin
         bus.corr_valid <= 1'b0;
         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  if (beat == LAST_BEAT) begin
                     bus.corr_out   <= acc_sum;
                     bus.corr_idx   <= col;
                     bus.corr_valid <= 1'b1;
                     acc            <= '0;
                     beat           <= '0;
                     if (col == LAST_COL) begin
                        col          <= '0;
                        bus.in_ready <= 1'b0;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end else begin
                     acc  <= acc_sum;
                     beat <= beat + 1'b1;
                  end
               end
               // Column 0 loads unconditionally; later ties keep the lower index.
               if (bus.corr_valid) begin
                  if (bus.corr_idx == '0 || greater) begin
                     bus.max_val <= abs_val;
                     bus.max_idx <= bus.corr_idx;
                  end
                  if (bus.corr_idx == LAST_COL) begin
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                  end
               end
            end
            ST_IDLE, ST_DONE: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_corr_argmax.sv
// Directed bench for corr_argmax with BEATS=4, COLS=4, DATA_WIDTH=16.
module tb_corr_argmax;

   localparam int DW    = 16;
   localparam int BEATS = 4;
   localparam int COLS  = 4;

   logic clk;
   logic rst;

   int total = 0;
   int bad   = 0;
   int stalls = 0;

   logic signed [17:0] cv_val_q[$];
   int                 cv_idx_q[$];

   corr_argmax_if #(.DATA_WIDTH(DW), .BEATS(BEATS), .COLS(COLS)) bus ();

   corr_argmax #(.DATA_WIDTH(DW), .BEATS(BEATS), .COLS(COLS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every corr_valid pulse with its payload.
   always @(negedge clk) begin
      if (bus.corr_valid === 1'b1) begin
         cv_val_q.push_back(bus.corr_out);
         cv_idx_q.push_back(int'(bus.corr_idx));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] got_val(input int i);
      return (i < cv_val_q.size()) ? 64'(cv_val_q[i]) : 64'sd999999;
   endfunction

   function automatic logic signed [63:0] got_idx(input int i);
      return (i < cv_idx_q.size()) ? 64'(cv_idx_q[i]) : 64'sd999;
   endfunction

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_beat(input logic signed [15:0] v);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("beat_timeout", 64'(bus.in_ready), 64'sd1);
      stalls += n;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_col(input int b0, input int b1, input int b2, input int b3,
                           input int gap_max);
      int beats[4];
      beats = '{b0, b1, b2, b3};
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
         send_beat(16'(beats[i]));
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(bus.done), 64'sd1);
   endtask

   task automatic check_run(input string tag, input int base,
                            input int e0, input int e1, input int e2, input int e3);
      int e[4];
      e = '{e0, e1, e2, e3};
      #1;
      check({tag, "_pulses"}, 64'(cv_val_q.size() - base), 64'sd4);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_corr"}, got_val(base + i), 64'(e[i]));
         check({tag, "_idx"}, got_idx(base + i), 64'(i));
      end
   endtask

   initial begin
      int base;
      int b2b[16];
      b2b = '{1, 2, 3, 4, -5, -6, -7, -8, 9, 10, 11, 12, 13, 14, 15, 16};

      rst = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'sd0);
      check("rst_corr_valid", 64'(bus.corr_valid), 64'sd0);
      check("rst_corr_out", 64'(bus.corr_out), 64'sd0);
      check("rst_max_val", 64'(bus.max_val), 64'sd0);
      check("rst_done", 64'(bus.done), 64'sd0);
      rst = 1'b1;

      // In IDLE, valid beats are ignored.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 16'sd100;
      repeat (6) @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("idle_no_pulse", 64'(cv_val_q.size()), 64'sd0);
      check("idle_in_ready", 64'(bus.in_ready), 64'sd0);

      // Basic search: sums 10, -25, 7, 25; tie at 25 keeps column 1.
      pulse_start();
      check("start_in_ready", 64'(bus.in_ready), 64'sd1);
      base = cv_val_q.size();
      send_col(5, 5, 0, 0, 0);
      send_col(-25, 0, 0, 0, 0);
      send_col(1, 2, 3, 1, 0);
      send_col(10, 10, 5, 0, 0);
      wait_done("basic_done");
      check_run("basic", base, 10, -25, 7, 25);
      check("basic_max_val", 64'(bus.max_val), 64'sd25);
      check("basic_max_idx", 64'(bus.max_idx), 64'sd1);
      check("basic_in_ready", 64'(bus.in_ready), 64'sd0);

      // DONE holds and ignores in_valid.
      bus.in_valid = 1'b1;
      bus.in_data = 16'sd500;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("done_no_pulse", 64'(cv_val_q.size() - base), 64'sd4);
      check("done_hold", 64'(bus.done), 64'sd1);
      check("done_max_val", 64'(bus.max_val), 64'sd25);
      check("done_max_idx", 64'(bus.max_idx), 64'sd1);

      // Same data with random in_valid gaps.
      pulse_start();
      check("stall_done_clr", 64'(bus.done), 64'sd0);
      base = cv_val_q.size();
      send_col(5, 5, 0, 0, 3);
      send_col(-25, 0, 0, 0, 3);
      send_col(1, 2, 3, 1, 3);
      send_col(10, 10, 5, 0, 3);
      wait_done("stall_done");
      repeat (3) @(negedge clk);
      check_run("stall", base, 10, -25, 7, 25);
      check("stall_max_val", 64'(bus.max_val), 64'sd25);
      check("stall_max_idx", 64'(bus.max_idx), 64'sd1);

      // Saturation: four beats of -32768.
      pulse_start();
      send_col(-32768, -32768, -32768, -32768, 0);
      check("sat_corr_valid", 64'(bus.corr_valid), 64'sd1);
      check("sat_corr_out", 64'(bus.corr_out), -64'sd131072);
      @(negedge clk);
      check("sat_max_val", 64'(bus.max_val), 64'sd131071);
      check("sat_max_idx", 64'(bus.max_idx), 64'sd0);

      // Abort after two columns, with column 1's max update still pending.
      send_col(1, 0, 0, 0, 0);
      pulse_start();
      check("abort_max_val", 64'(bus.max_val), 64'sd0);
      check("abort_max_idx", 64'(bus.max_idx), 64'sd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'sd1);
      check("abort_done", 64'(bus.done), 64'sd0);
      #1;
      base = cv_val_q.size();
      send_col(1, 0, 0, 0, 0);
      send_col(2, 0, 0, 0, 0);
      send_col(3, 0, 0, 0, 0);
      send_col(-4, 0, 0, 0, 0);
      wait_done("abort_done_end");
      check_run("abort", base, 1, 2, 3, -4);
      check("abort_new_max_val", 64'(bus.max_val), 64'sd4);
      check("abort_new_max_idx", 64'(bus.max_idx), 64'sd3);

      // Back-to-back: 16 beats with no bubbles; done two cycles after last beat.
      pulse_start();
      #1;
      base = cv_val_q.size();
      stalls = 0;
      for (int i = 0; i < 16; i++) send_beat(16'(b2b[i]));
      check("b2b_stalls", 64'(stalls), 64'sd0);
      check("b2b_corr_valid", 64'(bus.corr_valid), 64'sd1);
      check("b2b_done_early", 64'(bus.done), 64'sd0);
      @(negedge clk);
      check("b2b_done", 64'(bus.done), 64'sd1);
      check_run("b2b", base, 10, -26, 42, 58);
      check("b2b_max_val", 64'(bus.max_val), 64'sd58);
      check("b2b_max_idx", 64'(bus.max_idx), 64'sd3);

      // Reset in the middle of a column.
      pulse_start();
      send_col(9, 0, 0, 0, 0);
      send_col(20, 0, 0, 0, 0);
      send_beat(16'sd7);
      send_beat(16'sd8);
      @(negedge clk);
      check("pre_rst_max_val", 64'(bus.max_val), 64'sd20);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'sd0);
      check("mid_rst_corr_out", 64'(bus.corr_out), 64'sd0);
      check("mid_rst_corr_idx", 64'(bus.corr_idx), 64'sd0);
      check("mid_rst_max_val", 64'(bus.max_val), 64'sd0);
      check("mid_rst_max_idx", 64'(bus.max_idx), 64'sd0);
      check("mid_rst_done", 64'(bus.done), 64'sd0);
      @(negedge clk);
      rst = 1'b1;
      base = cv_val_q.size();
      bus.in_valid = 1'b1;
      bus.in_data = 16'sd3;
      repeat (8) @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_no_pulse", 64'(cv_val_q.size() - base), 64'sd0);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'sd0);
      pulse_start();
      check("post_rst_start", 64'(bus.in_ready), 64'sd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/corr_argmax.md
CORR_ARGMAX -- requirements
Module: corr_argmax

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `VMU_DATA_WIDTH, width of each adder-tree dot-product partial sum.
REQ-002 SHALL have parameter BEATS, default 4, number of partial sums per column inner product (>=2).
REQ-003 SHALL have parameter COLS, default 256, number of dictionary columns per search (>=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse opening a new search.
REQ-008 SHALL have port in_valid, input, 1, in_data carries a valid partial sum.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, signed partial sum from the adder tree in dot-product mode.
REQ-010 SHALL have port in_ready, output, 1, high only in ACCUM.
REQ-011 SHALL have port corr_valid, output, 1, one-cycle pulse per completed column.
REQ-012 SHALL have port corr_out, output, ACC_W, signed column inner product, ACC_W = DATA_WIDTH+$clog2(BEATS).
REQ-013 SHALL have port corr_idx, output, $clog2(COLS), column index of corr_out.
REQ-014 SHALL have port max_val, output, ACC_W, unsigned largest |inner product| so far.
REQ-015 SHALL have port max_idx, output, $clog2(COLS), column of max_val.
REQ-016 SHALL have port done, output, 1, level, high in DONE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCUM on start; ACCUM -> DONE after final column's max update; DONE -> ACCUM on start.
REQ-018 SHALL accept a beat when in_valid && in_ready; in_valid gaps only stall, with no state loss.
REQ-019 SHALL sign-extend in_data to ACC_W and add it to the accumulator; ACC_W holds BEATS worst-case values without overflow.
REQ-020 SHALL count accepted beats 0..BEATS-1; on acceptance of beat BEATS-1, register acc+in_data into corr_out, current column into corr_idx, and pulse corr_valid the next cycle (T+1); accumulator and beat count clear in that same cycle.
REQ-021 SHALL compute |corr_out| at T+1 and update max_val/max_idx at T+2 only when |corr_out| > max_val (strict; ties keep lower index).
REQ-022 SHALL saturate |-2^(ACC_W-1)| to 2^(ACC_W-1)-1.
REQ-023 SHALL, for the first column of a search, load max_val/max_idx unconditionally.
REQ-024 SHALL assert done at T+2 of column COLS-1 and hold until start or reset; max_val/max_idx stay stable in DONE.
REQ-025 SHALL treat start in ACCUM as abort-and-restart: next cycle counters, accumulator, max_val, max_idx clear and the pipeline's pending corr_valid/max update is cancelled.
REQ-026 SHALL ignore in_valid outside ACCUM; back-to-back columns with no bubbles SHALL be supported (one beat per cycle sustained).

Reset
REQ-027 SHALL on rst low immediately enter IDLE and clear in_ready, corr_valid, corr_out, corr_idx, max_val, max_idx, done, accumulator, counters.
REQ-028 SHALL leave IDLE only on a start sampled after rst deasserts.

Structure
REQ-029 SHALL take DATA_WIDTH from define.vh; FSM state encodings and the ACC_W/index-width derivations belong in the shared header.
REQ-030 SHALL factor the |x| saturate-and-compare into one sub-module, abs_max_cmp; everything else flat.

Verification (BEATS=4, COLS=4, DATA_WIDTH=16)
REQ-031 SHALL check reset: rst low mid-ACCUM -> all outputs 0, in_ready 0, no corr_valid after release until start.
REQ-032 SHALL check basic search: column sums 10, -25, 7, 25 (beats e.g. 5,5,0,0 / -25,0,0,0 / ...) -> corr_out sequence 10,-25,7,25, max_idx=1, max_val=25, done high.
REQ-033 SHALL check stalls: same data with random in_valid gaps -> identical results, exactly 4 corr_valid pulses.
REQ-034 SHALL check saturation: one column of four beats -32768 -> corr_out=-131072, max_val=131071.
REQ-035 SHALL check abort: start after 2 columns, then new columns 1,2,3,-4 -> max_idx=3, max_val=4, no stale max from aborted run.
REQ-036 SHALL check back-to-back: 16 consecutive valid beats -> done exactly 2 cycles after last beat accepted.
